// File: rtl/sram_1rw_arb_pkg.sv
// ----------------------------------------------------------------------------
// sram_1rw_arb_pkg
// Shared types and helpers for the two-client 1RW SRAM arbiter.
//   state_t     : sequencer state (INIT = zero-fill in progress, RUN = serving)
//   CLIENTS_N   : number of arbitrated clients
//   slice_base  : lowest bit index of a client's field inside a packed
//                 per-client bus (client i occupies [i*width +: width])
// ----------------------------------------------------------------------------
package sram_1rw_arb_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int CLIENTS_N = 2;

    function automatic int slice_base(input int client, input int width);
        return client * width;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// ----------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin arbiter. A lone requester always wins; when both
// request, the pointer picks the winner. After every accepted grant the
// pointer moves to the client that did not win.
//   clk, rst : clock, synchronous active-high reset (pointer -> client 0)
//   req      : per-client request
//   ack      : the current grant is being taken this cycle
//   gnt      : one-hot (or zero) grant, combinational from req and pointer
// ----------------------------------------------------------------------------
module rr_arb2
    import sram_1rw_arb_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [CLIENTS_N-1:0] req,
    input  logic                 ack,
    output logic [CLIENTS_N-1:0] gnt
);

    // ptr = 0 favours client 0, ptr = 1 favours client 1
    logic ptr;

    // Grant selection: the pointer only matters on a tie
    always_comb begin
        gnt = 2'b00;
        if (req == 2'b11) begin
            gnt = ptr ? 2'b10 : 2'b01;
        end else begin
            gnt = req;
        end
    end

    // Pointer update: after granting client 0 favour client 1 and vice versa,
    // which is exactly gnt[0]
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= 1'b0;
        end else if (ack && (gnt != 2'b00)) begin
            ptr <= gnt[0];
        end
    end

endmodule

// File: rtl/sram_1rw_arb.sv
// ----------------------------------------------------------------------------
// sram_1rw_arb
// Two-client arbiter/sequencer in front of a single-port synchronous SRAM
// with 1-cycle registered read data. Zero-fills the array after reset
// (INIT_EN=1), then round-robin arbitrates client commands onto the SRAM
// port and returns read data through a per-client response register.
//   clk, rst        : clock, synchronous active-high reset
//   init_done       : zero-fill complete, commands accepted
//   cmd_valid_i/cmd_ready_o/cmd_we_i/cmd_addr_i/cmd_wdata_i : per-client command
//   rsp_valid_o/rsp_ready_i/rsp_rdata_o                     : per-client response
//   sram_addr/sram_din/sram_ce/sram_oe/sram_dout            : SRAM macro port
// ----------------------------------------------------------------------------
module sram_1rw_arb
    import sram_1rw_arb_pkg::*;
#(
    parameter  int W       = 32,
    parameter  int N       = 256,
    parameter  bit INIT_EN = 1'b1,
    localparam int A       = $clog2(N)
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   init_done,
    input  logic [CLIENTS_N-1:0]   cmd_valid_i,
    output logic [CLIENTS_N-1:0]   cmd_ready_o,
    input  logic [CLIENTS_N-1:0]   cmd_we_i,
    input  logic [CLIENTS_N*A-1:0] cmd_addr_i,
    input  logic [CLIENTS_N*W-1:0] cmd_wdata_i,
    output logic [CLIENTS_N-1:0]   rsp_valid_o,
    input  logic [CLIENTS_N-1:0]   rsp_ready_i,
    output logic [CLIENTS_N*W-1:0] rsp_rdata_o,
    output logic [A-1:0]           sram_addr,
    output logic [W-1:0]           sram_din,
    output logic                   sram_ce,
    output logic                   sram_oe,
    input  logic [W-1:0]           sram_dout
);

    localparam logic [A-1:0] LAST_ADDR = A'(N - 1);

    state_t               state;
    state_t               state_nxt;
    logic [A-1:0]         cnt;
    logic [CLIENTS_N-1:0] pend;
    logic [CLIENTS_N-1:0] elig;
    logic [CLIENTS_N-1:0] gnt;
    logic                 run_en;
    logic                 init_active;
    logic                 win;

    // SRAM and command outputs are held quiet while rst is asserted so the
    // macro sees no access during the reset cycle itself
    assign run_en      = (state == RUN) && !rst;
    assign init_active = (state == INIT) && !rst;
    assign init_done   = (state == RUN);
    assign cmd_ready_o = gnt;
    assign win         = gnt[1];

    // A read needs a free response slot: nothing in flight and the register
    // either empty or being popped this very cycle (pop bypass)
    always_comb begin
        elig = '0;
        for (int i = 0; i < CLIENTS_N; i++) begin
            elig[i] = run_en && cmd_valid_i[i] &&
                      (cmd_we_i[i] || (!pend[i] && (!rsp_valid_o[i] || rsp_ready_i[i])));
        end
    end

    rr_arb2 u_arb (
        .clk (clk),
        .rst (rst),
        .req (elig),
        .ack (|gnt),
        .gnt (gnt)
    );

    // SRAM port mux: zero-fill address during INIT, granted client in RUN
    always_comb begin
        sram_ce   = 1'b0;
        sram_oe   = 1'b0;
        sram_addr = '0;
        sram_din  = '0;
        if (init_active) begin
            sram_ce   = 1'b1;
            sram_addr = cnt;
        end else if (|gnt) begin
            sram_ce   = 1'b1;
            sram_oe   = ~cmd_we_i[win];
            sram_addr = cmd_addr_i[slice_base(int'(win), A) +: A];
            sram_din  = cmd_wdata_i[slice_base(int'(win), W) +: W];
        end
    end

    // Leave INIT right after the last word has been written
    always_comb begin
        state_nxt = state;
        if ((state == INIT) && (cnt == LAST_ADDR)) begin
            state_nxt = RUN;
        end
    end

    // State register and zero-fill address counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= INIT_EN ? INIT : RUN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (state == INIT) begin
                cnt <= cnt + A'(1);
            end
        end
    end

    // Read return path: pend marks the cycle the SRAM data is on sram_dout;
    // it is captured into the client's response register one cycle later
    always_ff @(posedge clk) begin
        if (rst) begin
            pend        <= '0;
            rsp_valid_o <= '0;
            rsp_rdata_o <= '0;
        end else begin
            for (int i = 0; i < CLIENTS_N; i++) begin
                pend[i] <= gnt[i] & ~cmd_we_i[i];
                if (pend[i]) begin
                    rsp_valid_o[i]                     <= 1'b1;
                    rsp_rdata_o[slice_base(i, W) +: W] <= sram_dout;
                end else if (rsp_ready_i[i]) begin
                    rsp_valid_o[i] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_sram_1rw_arb.sv
// ----------------------------------------------------------------------------
// tb_sram_1rw_arb
// Self-checking bench for sram_1rw_arb (W=32, N=16). Drives a behavioural
// SRAM macro and compares the DUT every cycle against a reference model that
// tracks memory contents, the favoured client and a timestamped response
// slot per client. Hand-written sequences and a vector table cover the
// multi-cycle corner cases; a random phase follows.
// ----------------------------------------------------------------------------
module tb_sram_1rw_arb;

    localparam int W = 32;
    localparam int N = 16;
    localparam int A = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           init_done;
    logic [1:0]     cmd_valid;
    logic [1:0]     cmd_ready_o;
    logic [1:0]     cmd_we;
    logic [2*A-1:0] cmd_addr;
    logic [2*W-1:0] cmd_wdata;
    logic [1:0]     rsp_valid_o;
    logic [1:0]     rsp_ready;
    logic [2*W-1:0] rsp_rdata_o;
    logic [A-1:0]   sram_addr;
    logic [W-1:0]   sram_din;
    logic           sram_ce;
    logic           sram_oe;
    logic [W-1:0]   sram_dout;
    logic           preload;

    int vectors    = 0;
    int miscompares = 0;
    int cyc        = 0;

    // Reference model state
    logic [W-1:0] ref_mem [N];
    int           fav;
    bit           has_rsp [2];
    int           vis_cyc [2];
    logic [W-1:0] rsp_val [2];

    typedef struct {
        logic [1:0]   valid;
        logic [1:0]   we;
        logic [A-1:0] a0;
        logic [A-1:0] a1;
        logic [W-1:0] wd0;
        logic [W-1:0] wd1;
        logic [1:0]   exp_rdy;
        logic         exp_ce;
        logic         exp_oe;
        logic [A-1:0] exp_addr;
        logic [W-1:0] exp_din;
        logic [1:0]   exp_rv;
        logic [W-1:0] exp_rd0;
        logic [W-1:0] exp_rd1;
    } vec_t;

    vec_t tbl [15];

    always #5 clk = ~clk;

    sram_1rw_arb #(.W(W), .N(N), .INIT_EN(1'b1)) dut (
        .clk         (clk),
        .rst         (rst),
        .init_done   (init_done),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready_o),
        .cmd_we_i    (cmd_we),
        .cmd_addr_i  (cmd_addr),
        .cmd_wdata_i (cmd_wdata),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready),
        .rsp_rdata_o (rsp_rdata_o),
        .sram_addr   (sram_addr),
        .sram_din    (sram_din),
        .sram_ce     (sram_ce),
        .sram_oe     (sram_oe),
        .sram_dout   (sram_dout)
    );

    // SRAM macro: registered read data, garbage preloaded so zero-fill matters
    logic [W-1:0] sram_mem [N];
    always @(posedge clk) begin
        if (preload) begin
            for (int k = 0; k < N; k++) sram_mem[k] <= $urandom;
        end else if (sram_ce) begin
            if (sram_oe) sram_dout <= sram_mem[sram_addr];
            else         sram_mem[sram_addr] <= sram_din;
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic applyStimulus(input logic [1:0] v, input logic [1:0] we,
                                 input logic [A-1:0] a0, input logic [A-1:0] a1,
                                 input logic [W-1:0] wd0, input logic [W-1:0] wd1,
                                 input logic [1:0] rr);
        cmd_valid = v;
        cmd_we    = we;
        cmd_addr  = {a1, a0};
        cmd_wdata = {wd1, wd0};
        rsp_ready = rr;
        #1;
    endtask

    task automatic modelReset();
        fav = 0;
        for (int i = 0; i < 2; i++) begin
            has_rsp[i] = 1'b0;
            vis_cyc[i] = 0;
            rsp_val[i] = '0;
        end
        for (int k = 0; k < N; k++) ref_mem[k] = '0;
    endtask

    // Predict this cycle's grant and responses, compare, then commit the
    // effects of the coming clock edge into the model
    task automatic modelCheckAndCommit();
        bit           vis [2];
        bit           ok [2];
        int           g;
        logic [A-1:0] ga;
        logic [W-1:0] gd;
        bit           gwe;
        ga  = '0;
        gd  = '0;
        gwe = 1'b0;
        for (int i = 0; i < 2; i++) begin
            vis[i] = has_rsp[i] && (vis_cyc[i] <= cyc);
            ok[i]  = cmd_valid[i] && (cmd_we[i] || !has_rsp[i] || (vis[i] && rsp_ready[i]));
        end
        if (ok[0] && ok[1]) g = fav;
        else if (ok[0])     g = 0;
        else if (ok[1])     g = 1;
        else                g = -1;
        checkOutput("cmd_ready", 64'(cmd_ready_o), (g < 0) ? 64'd0 : 64'(2'b01 << g));
        checkOutput("sram_ce", 64'(sram_ce), 64'(g >= 0));
        for (int i = 0; i < 2; i++) begin
            checkOutput("rsp_valid", 64'(rsp_valid_o[i]), 64'(vis[i]));
            if (vis[i]) checkOutput("rsp_rdata", 64'(rsp_rdata_o[i*W +: W]), 64'(rsp_val[i]));
        end
        if (g >= 0) begin
            ga  = cmd_addr[g*A +: A];
            gd  = cmd_wdata[g*W +: W];
            gwe = cmd_we[g];
            checkOutput("sram_oe", 64'(sram_oe), 64'(!gwe));
            checkOutput("sram_addr", 64'(sram_addr), 64'(ga));
            if (gwe) checkOutput("sram_din", 64'(sram_din), 64'(gd));
        end
        for (int i = 0; i < 2; i++) begin
            if (vis[i] && rsp_ready[i]) has_rsp[i] = 1'b0;
        end
        if (g >= 0) begin
            if (gwe) begin
                ref_mem[ga] = gd;
            end else begin
                has_rsp[g] = 1'b1;
                rsp_val[g] = ref_mem[ga];
                vis_cyc[g] = cyc + 2;
            end
            fav = 1 - g;
        end
    endtask

    task automatic cycleIdle();
        applyStimulus(2'b00, 2'b00, '0, '0, '0, '0, 2'b11);
        modelCheckAndCommit();
        step();
    endtask

    task automatic resetPulse();
        rst = 1'b1;
        #1;
        checkOutput("rst_ce", 64'(sram_ce), 64'd0);
        checkOutput("rst_ready", 64'(cmd_ready_o), 64'd0);
        step();
        rst = 1'b0;
        #1;
        modelReset();
    endtask

    // Zero-fill walk: ce=1, oe=0, addr=k, din=0, nothing accepted or returned
    task automatic checkInit(input int ncyc);
        for (int k = 0; k < ncyc; k++) begin
            checkOutput("init_ce", 64'(sram_ce), 64'd1);
            checkOutput("init_oe", 64'(sram_oe), 64'd0);
            checkOutput("init_addr", 64'(sram_addr), 64'(k));
            checkOutput("init_din", 64'(sram_din), 64'd0);
            checkOutput("init_ready", 64'(cmd_ready_o), 64'd0);
            checkOutput("init_done_low", 64'(init_done), 64'd0);
            checkOutput("init_rsp_valid", 64'(rsp_valid_o), 64'd0);
            step();
        end
        if (ncyc == N) checkOutput("init_done_high", 64'(init_done), 64'd1);
    endtask

    initial begin
        logic [W-1:0] exp10;

        tbl[0]  = '{2'b11, 2'b11, 4'd1, 4'd2, 32'hA0000001, 32'hB0000002, 2'b01, 1'b1, 1'b0, 4'd1, 32'hA0000001, 2'b00, 32'h0, 32'h0};
        tbl[1]  = '{2'b11, 2'b11, 4'd6, 4'd2, 32'hA0000006, 32'hB0000002, 2'b10, 1'b1, 1'b0, 4'd2, 32'hB0000002, 2'b00, 32'h0, 32'h0};
        tbl[2]  = '{2'b10, 2'b10, 4'd0, 4'd3, 32'h0,        32'hB0000003, 2'b10, 1'b1, 1'b0, 4'd3, 32'hB0000003, 2'b00, 32'h0, 32'h0};
        tbl[3]  = '{2'b11, 2'b11, 4'd5, 4'd4, 32'hA0000005, 32'hB0000004, 2'b01, 1'b1, 1'b0, 4'd5, 32'hA0000005, 2'b00, 32'h0, 32'h0};
        tbl[4]  = '{2'b00, 2'b00, 4'd0, 4'd0, 32'h0,        32'h0,        2'b00, 1'b0, 1'b0, 4'd0, 32'h0,        2'b00, 32'h0, 32'h0};
        tbl[5]  = '{2'b11, 2'b11, 4'd7, 4'd4, 32'hA0000007, 32'hB0000004, 2'b10, 1'b1, 1'b0, 4'd4, 32'hB0000004, 2'b00, 32'h0, 32'h0};
        tbl[6]  = '{2'b01, 2'b00, 4'd1, 4'd0, 32'h0,        32'h0,        2'b01, 1'b1, 1'b1, 4'd1, 32'h0,        2'b00, 32'h0, 32'h0};
        tbl[7]  = '{2'b01, 2'b00, 4'd1, 4'd0, 32'h0,        32'h0,        2'b00, 1'b0, 1'b0, 4'd0, 32'h0,        2'b00, 32'h0, 32'h0};
        tbl[8]  = '{2'b00, 2'b00, 4'd0, 4'd0, 32'h0,        32'h0,        2'b00, 1'b0, 1'b0, 4'd0, 32'h0,        2'b01, 32'hA0000001, 32'h0};
        tbl[9]  = '{2'b10, 2'b00, 4'd0, 4'd3, 32'h0,        32'h0,        2'b10, 1'b1, 1'b1, 4'd3, 32'h0,        2'b00, 32'h0, 32'h0};
        tbl[10] = '{2'b11, 2'b01, 4'd3, 4'd2, 32'hC0000003, 32'h0,        2'b01, 1'b1, 1'b0, 4'd3, 32'hC0000003, 2'b00, 32'h0, 32'h0};
        tbl[11] = '{2'b00, 2'b00, 4'd0, 4'd0, 32'h0,        32'h0,        2'b00, 1'b0, 1'b0, 4'd0, 32'h0,        2'b10, 32'h0, 32'hB0000003};
        tbl[12] = '{2'b10, 2'b00, 4'd0, 4'd3, 32'h0,        32'h0,        2'b10, 1'b1, 1'b1, 4'd3, 32'h0,        2'b00, 32'h0, 32'h0};
        tbl[13] = '{2'b00, 2'b00, 4'd0, 4'd0, 32'h0,        32'h0,        2'b00, 1'b0, 1'b0, 4'd0, 32'h0,        2'b00, 32'h0, 32'h0};
        tbl[14] = '{2'b00, 2'b00, 4'd0, 4'd0, 32'h0,        32'h0,        2'b00, 1'b0, 1'b0, 4'd0, 32'h0,        2'b10, 32'h0, 32'hC0000003};

        // Reset, abort INIT at cnt=7, then a full zero-fill with commands pending
        preload = 1'b1;
        applyStimulus(2'b11, 2'b11, 4'd9, 4'd9, 32'hFFFF0000, 32'h0000FFFF, 2'b00);
        resetPulse();
        preload = 1'b0;
        checkInit(7);
        checkOutput("init_cnt7_addr", 64'(sram_addr), 64'd7);
        resetPulse();
        checkInit(N);

        // Continuous writes from both: strict alternation starting with client 0
        for (int k = 0; k < 8; k++) begin
            applyStimulus(2'b11, 2'b11, 4'($urandom_range(0, N-1)), 4'($urandom_range(0, N-1)),
                          $urandom, $urandom, 2'b11);
            checkOutput("alt_grant", 64'(cmd_ready_o), (k % 2 == 0) ? 64'd1 : 64'd2);
            modelCheckAndCommit();
            step();
        end

        // Same address, same cycle: write 0x1234 from client 0 wins, read sees it
        applyStimulus(2'b11, 2'b01, 4'd3, 4'd3, 32'h1234, 32'h0, 2'b11);
        checkOutput("same_addr_wr_first", 64'(cmd_ready_o), 64'd1);
        modelCheckAndCommit();
        step();
        applyStimulus(2'b10, 2'b00, 4'd3, 4'd3, 32'h0, 32'h0, 2'b11);
        checkOutput("same_addr_rd_second", 64'(cmd_ready_o), 64'd2);
        modelCheckAndCommit();
        step();
        applyStimulus(2'b00, 2'b00, '0, '0, '0, '0, 2'b11);
        checkOutput("same_addr_rv_t1", 64'(rsp_valid_o[1]), 64'd0);
        modelCheckAndCommit();
        step();
        applyStimulus(2'b00, 2'b00, '0, '0, '0, '0, 2'b11);
        checkOutput("same_addr_rv_t2", 64'(rsp_valid_o[1]), 64'd1);
        checkOutput("same_addr_rdata", 64'(rsp_rdata_o[W +: W]), 64'h1234);
        modelCheckAndCommit();
        step();

        // Vector table
        for (int r = 0; r < 15; r++) begin
            applyStimulus(tbl[r].valid, tbl[r].we, tbl[r].a0, tbl[r].a1, tbl[r].wd0, tbl[r].wd1, 2'b11);
            checkOutput("tbl_ready", 64'(cmd_ready_o), 64'(tbl[r].exp_rdy));
            checkOutput("tbl_ce", 64'(sram_ce), 64'(tbl[r].exp_ce));
            if (tbl[r].exp_ce) begin
                checkOutput("tbl_oe", 64'(sram_oe), 64'(tbl[r].exp_oe));
                checkOutput("tbl_addr", 64'(sram_addr), 64'(tbl[r].exp_addr));
                if (!tbl[r].exp_oe) checkOutput("tbl_din", 64'(sram_din), 64'(tbl[r].exp_din));
            end
            checkOutput("tbl_rsp_valid", 64'(rsp_valid_o), 64'(tbl[r].exp_rv));
            if (tbl[r].exp_rv[0]) checkOutput("tbl_rdata0", 64'(rsp_rdata_o[0 +: W]), 64'(tbl[r].exp_rd0));
            if (tbl[r].exp_rv[1]) checkOutput("tbl_rdata1", 64'(rsp_rdata_o[W +: W]), 64'(tbl[r].exp_rd1));
            modelCheckAndCommit();
            step();
        end

        // Write 0xDEADBEEF @5 then read it back: 2-cycle latency
        applyStimulus(2'b01, 2'b01, 4'd5, 4'd0, 32'hDEADBEEF, 32'h0, 2'b11);
        checkOutput("wr5_ready", 64'(cmd_ready_o), 64'd1);
        modelCheckAndCommit();
        step();
        applyStimulus(2'b01, 2'b00, 4'd5, 4'd0, 32'h0, 32'h0, 2'b11);
        checkOutput("rd5_ready", 64'(cmd_ready_o), 64'd1);
        modelCheckAndCommit();
        step();
        applyStimulus(2'b00, 2'b00, '0, '0, '0, '0, 2'b11);
        checkOutput("rd5_rv_t1", 64'(rsp_valid_o[0]), 64'd0);
        modelCheckAndCommit();
        step();
        applyStimulus(2'b00, 2'b00, '0, '0, '0, '0, 2'b11);
        checkOutput("rd5_rv_t2", 64'(rsp_valid_o[0]), 64'd1);
        checkOutput("rd5_rdata", 64'(rsp_rdata_o[0 +: W]), 64'hDEADBEEF);
        modelCheckAndCommit();
        step();
        applyStimulus(2'b00, 2'b00, '0, '0, '0, '0, 2'b11);
        checkOutput("rd5_rv_popped", 64'(rsp_valid_o[0]), 64'd0);
        modelCheckAndCommit();
        step();

        // Client 1 response backpressured for 5 cycles, second read waits for pop
        applyStimulus(2'b10, 2'b10, 4'd0, 4'd9, 32'h0, 32'h5555AAAA, 2'b11);
        modelCheckAndCommit();
        step();
        applyStimulus(2'b10, 2'b00, 4'd0, 4'd9, 32'h0, 32'h0, 2'b00);
        checkOutput("bp_first_rd", 64'(cmd_ready_o), 64'd2);
        modelCheckAndCommit();
        step();
        for (int k = 0; k < 5; k++) begin
            applyStimulus(2'b10, 2'b00, 4'd0, 4'd10, 32'h0, 32'h0, 2'b00);
            checkOutput("bp_blocked", 64'(cmd_ready_o[1]), 64'd0);
            if (k >= 1) begin
                checkOutput("bp_rv_held", 64'(rsp_valid_o[1]), 64'd1);
                checkOutput("bp_rdata_held", 64'(rsp_rdata_o[W +: W]), 64'h5555AAAA);
            end
            modelCheckAndCommit();
            step();
        end
        exp10 = ref_mem[10];
        applyStimulus(2'b10, 2'b00, 4'd0, 4'd10, 32'h0, 32'h0, 2'b10);
        checkOutput("bp_pop_bypass", 64'(cmd_ready_o), 64'd2);
        checkOutput("bp_pop_rdata", 64'(rsp_rdata_o[W +: W]), 64'h5555AAAA);
        modelCheckAndCommit();
        step();
        applyStimulus(2'b00, 2'b00, '0, '0, '0, '0, 2'b10);
        checkOutput("bp_second_t1", 64'(rsp_valid_o[1]), 64'd0);
        modelCheckAndCommit();
        step();
        applyStimulus(2'b00, 2'b00, '0, '0, '0, '0, 2'b11);
        checkOutput("bp_second_rv", 64'(rsp_valid_o[1]), 64'd1);
        checkOutput("bp_second_rdata", 64'(rsp_rdata_o[W +: W]), 64'(exp10));
        modelCheckAndCommit();
        step();

        // Random traffic against the reference model
        for (int k = 0; k < 2000; k++) begin
            applyStimulus(2'($urandom), 2'($urandom),
                          4'($urandom_range(0, N-1)), 4'($urandom_range(0, N-1)),
                          $urandom, $urandom,
                          {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)});
            modelCheckAndCommit();
            step();
        end

        // Reset with a read in flight: response must be dropped
        for (int k = 0; k < 3; k++) cycleIdle();
        applyStimulus(2'b01, 2'b00, 4'd2, 4'd0, 32'h0, 32'h0, 2'b00);
        checkOutput("pre_rst_rd", 64'(cmd_ready_o), 64'd1);
        modelCheckAndCommit();
        step();
        resetPulse();
        checkInit(N);
        for (int k = 0; k < 4; k++) begin
            checkOutput("post_rst_rv", 64'(rsp_valid_o), 64'd0);
            cycleIdle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
